// File: rtl/status_branch_unit_pkg.sv
// Shared status-flag bit positions, branch condition codes and FSM encodings
// for the status branch unit and anything decoding ALU status.
package status_branch_unit_pkg;

  localparam int STS_ZERO = 2;
  localparam int STS_NEG  = 1;
  localparam int STS_OVF  = 0;

  localparam logic [2:0] COND_BZ  = 3'b000;
  localparam logic [2:0] COND_BNZ = 3'b001;
  localparam logic [2:0] COND_BN  = 3'b010;
  localparam logic [2:0] COND_BNN = 3'b011;
  localparam logic [2:0] COND_BO  = 3'b100;
  localparam logic [2:0] COND_BNO = 3'b101;
  localparam logic [2:0] COND_J   = 3'b110;
  localparam logic [2:0] COND_JR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // JR is the only condition whose target comes from a register.
  function automatic logic cond_uses_reg(input logic [2:0] cond);
    return cond == COND_JR;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition resolver: decides taken/not-taken from the
// latched status flags and the condition code.
module branch_cond_eval
  import status_branch_unit_pkg::*;
(
  input  logic [2:0] i_flags,
  input  logic [2:0] i_cond,
  output logic       o_taken
);

  logic w_zero;
  logic w_neg;
  logic w_ovf;

  assign w_zero = i_flags[STS_ZERO];
  assign w_neg  = i_flags[STS_NEG];
  assign w_ovf  = i_flags[STS_OVF];

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_BZ:  o_taken = w_zero;
      COND_BNZ: o_taken = !w_zero;
      COND_BN:  o_taken = w_neg;
      COND_BNN: o_taken = !w_neg;
      COND_BO:  o_taken = w_ovf;
      COND_BNO: o_taken = !w_ovf;
      COND_J:   o_taken = 1'b1;
      COND_JR:  o_taken = 1'b1;
      default:  o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_branch_unit.sv
// Status register plus a single-request branch resolver: IDLE -> EVAL -> DONE,
// with a held redirect to fetch for taken branches.
module status_branch_unit
  import status_branch_unit_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int OFFSET_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       sts_in,
  input  logic             stswrite,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_cond,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] br_offset,
  input  logic [WIDTH-1:0] reg_target,
  input  logic             flush,
  output logic             br_done,
  output logic             take,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [WIDTH-1:0] target,
  output logic [2:0]       status_q,
  output state_t           dbg_state
);

  // Handshakes: a request transfers on an edge with br_valid && br_ready and
  // no flush; a redirect transfers on an edge with redirect_valid &&
  // redirect_ready. redirect_valid and target stay stable until it transfers.

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_status;
  logic [2:0]       r_flags;
  logic [2:0]       r_cond;
  logic [WIDTH-1:0] r_pc4;
  logic [WIDTH-1:0] r_off;
  logic [WIDTH-1:0] r_regt;
  logic             r_done;
  logic             r_take;
  logic             r_rv;
  logic [WIDTH-1:0] r_target;

  logic             w_accept;
  logic             w_taken;
  logic [WIDTH-1:0] w_rel_target;
  logic [WIDTH-1:0] w_target;
  logic             w_leave_done;

  assign w_accept = br_valid && (r_state == ST_IDLE) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status <= 3'b000;
    end else if (stswrite) begin
      r_status <= sts_in;
    end
  end

  // Flags are snapshotted at accept; a same-cycle status write is forwarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= 3'b000;
      r_cond  <= 3'b000;
      r_pc4   <= '0;
      r_off   <= '0;
      r_regt  <= '0;
    end else if (w_accept) begin
      r_flags <= stswrite ? sts_in : r_status;
      r_cond  <= br_cond;
      r_pc4   <= pc_plus4;
      r_off   <= br_offset;
      r_regt  <= reg_target;
    end
  end

  branch_cond_eval u_eval (
    .i_flags (r_flags),
    .i_cond  (r_cond),
    .o_taken (w_taken)
  );

  assign w_rel_target = r_pc4 + (r_off << OFFSET_SHIFT);
  assign w_target     = cond_uses_reg(r_cond) ? r_regt : w_rel_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (br_valid) w_next = ST_EVAL;
        ST_EVAL: w_next = ST_DONE;
        ST_DONE: if (!r_take || redirect_ready) w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  assign w_leave_done = (r_state == ST_DONE) && (w_next == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done   <= 1'b0;
      r_take   <= 1'b0;
      r_rv     <= 1'b0;
      r_target <= '0;
    end else begin
      r_done <= (r_state == ST_EVAL) && !flush;
      if (flush) begin
        r_rv <= 1'b0;
      end else if (r_state == ST_EVAL) begin
        r_rv <= w_taken;
      end else if (r_rv && redirect_ready) begin
        r_rv <= 1'b0;
      end
      if ((r_state == ST_EVAL) && !flush) begin
        r_take   <= w_taken;
        r_target <= w_target;
      end else if (w_leave_done) begin
        r_take <= 1'b0;
      end
    end
  end

  assign br_ready       = (r_state == ST_IDLE);
  assign br_done        = r_done;
  assign take           = r_take;
  assign redirect_valid = r_rv;
  assign target         = r_target;
  assign status_q       = r_status;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_status_branch_unit.sv
// Directed bench for status_branch_unit: expected resolutions are queued at
// issue time and a negedge monitor compares them when br_done pulses.
module tb_status_branch_unit;
  import status_branch_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   sts_in = 3'b000;
  logic         stswrite = 1'b0;
  logic         br_valid = 1'b0;
  logic         br_ready;
  logic [2:0]   br_cond = 3'b000;
  logic [W-1:0] pc_plus4 = '0;
  logic [W-1:0] br_offset = '0;
  logic [W-1:0] reg_target = '0;
  logic         flush = 1'b0;
  logic         br_done;
  logic         take;
  logic         redirect_valid;
  logic         redirect_ready = 1'b1;
  logic [W-1:0] target;
  logic [2:0]   status_q;
  state_t       dbg_state;

  logic [W:0]   exp_q[$];
  int           exp_cyc_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  int           cyc = 0;

  typedef struct {
    logic [2:0]   sts;
    logic [2:0]   cond;
    logic [W-1:0] pc4;
    logic [W-1:0] off;
    logic [W-1:0] regt;
    logic         tk;
    logic [W-1:0] tgt;
  } vec_t;

  vec_t vecs[7];

  status_branch_unit #(.WIDTH(W), .OFFSET_SHIFT(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .sts_in         (sts_in),
    .stswrite       (stswrite),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_cond        (br_cond),
    .pc_plus4       (pc_plus4),
    .br_offset      (br_offset),
    .reg_target     (reg_target),
    .flush          (flush),
    .br_done        (br_done),
    .take           (take),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .target         (target),
    .status_q       (status_q),
    .dbg_state      (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Drivers: all called and returning on a negedge
  task automatic send(input logic [2:0] cond, input logic [W-1:0] pc4, input logic [W-1:0] off,
                      input logic [W-1:0] regt, input logic exp_take, input logic [W-1:0] exp_tgt,
                      input bit push);
    check("br_ready_before_send", br_ready, 1);
    br_valid   = 1'b1;
    br_cond    = cond;
    pc_plus4   = pc4;
    br_offset  = off;
    reg_target = regt;
    if (push) begin
      exp_q.push_back({exp_take, exp_tgt});
      exp_cyc_q.push_back(cyc + 2);
    end
    @(negedge clk);
    br_valid = 1'b0;
  endtask

  task automatic set_status(input logic [2:0] s);
    stswrite = 1'b1;
    sts_in   = s;
    @(negedge clk);
    stswrite = 1'b0;
    check("status_q_write", status_q, s);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!br_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", br_ready, 1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && br_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_br_done", br_done, 0);
      end else begin
        logic [W:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("take", take, e[W]);
        check("latency_cycle", cyc, ec);
        check("redirect_valid_with_done", redirect_valid, e[W]);
        if (e[W]) check("target", target, e[W-1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    vecs[0] = '{3'b001, COND_BO,  32'h2000, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'h1FFC};
    vecs[1] = '{3'b001, COND_BNO, 32'h3000, 32'h8,         32'h0,         1'b0, 32'h3020};
    vecs[2] = '{3'b010, COND_BN,  32'h400,  32'h3,         32'h0,         1'b1, 32'h40C};
    vecs[3] = '{3'b100, COND_BNZ, 32'h0,    32'h0,         32'h0,         1'b0, 32'h0};
    vecs[4] = '{3'b000, COND_BZ,  32'h0,    32'h0,         32'h0,         1'b0, 32'h0};
    vecs[5] = '{3'b000, COND_BNZ, 32'h10,   32'h20,        32'h0,         1'b1, 32'h90};
    vecs[6] = '{3'b110, COND_JR,  32'h0,    32'h0,         32'h1234_5678, 1'b1, 32'h1234_5678};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_br_ready", br_ready, 1);
    check("rst_br_done", br_done, 0);
    check("rst_take", take, 0);
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_target", target, 0);
    check("rst_status_q", status_q, 0);

    // Forwarding of a same-cycle status write into the request
    stswrite = 1'b1;
    sts_in   = 3'b100;
    send(COND_BZ, 32'h100, 32'h10, 32'h0, 1'b1, 32'h140, 1'b1);
    stswrite = 1'b0;
    check("fwd_status_q", status_q, 3'b100);
    wait_idle();

    // Not taken: one br_done, no redirect, IDLE at N+3
    set_status(3'b010);
    send(COND_BNN, 32'h200, 32'h4, 32'h0, 1'b0, 32'h210, 1'b1);
    @(negedge clk);
    check("nt_redirect_in_done", redirect_valid, 0);
    @(negedge clk);
    check("nt_idle_at_n3", br_ready, 1);
    check("nt_done_cleared", br_done, 0);
    check("nt_no_redirect", redirect_valid, 0);

    // Redirect stall on JR
    redirect_ready = 1'b0;
    send(COND_JR, 32'h0, 32'h0, 32'hDEAD_BEEC, 1'b1, 32'hDEAD_BEEC, 1'b1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (br_done) pulses++;
      check("stall_redirect_held", redirect_valid, 1);
      check("stall_target_held", target, 32'hDEAD_BEEC);
      check("stall_br_ready_low", br_ready, 0);
    end
    check("stall_done_pulses", pulses, 1);
    redirect_ready = 1'b1;
    @(negedge clk);
    check("stall_idle_after_hs", br_ready, 1);
    check("stall_redirect_dropped", redirect_valid, 0);

    // Address wrap
    send(COND_J, 32'hFFFF_FFFC, 32'h1, 32'h0, 1'b1, 32'h0, 1'b1);
    wait_idle();

    // Condition table
    for (int i = 0; i < 7; i++) begin
      set_status(vecs[i].sts);
      send(vecs[i].cond, vecs[i].pc4, vecs[i].off, vecs[i].regt, vecs[i].tk, vecs[i].tgt, 1'b1);
      wait_idle();
    end

    // Status write after accept must not change the outcome
    set_status(3'b100);
    send(COND_BZ, 32'h800, 32'h2, 32'h0, 1'b1, 32'h808, 1'b1);
    stswrite = 1'b1;
    sts_in   = 3'b000;
    @(negedge clk);
    stswrite = 1'b0;
    wait_idle();

    // Flush in EVAL, with a status write in the flush cycle
    send(COND_J, 32'h600, 32'h0, 32'h0, 1'b1, 32'h600, 1'b0);
    flush    = 1'b1;
    stswrite = 1'b1;
    sts_in   = 3'b011;
    @(negedge clk);
    flush    = 1'b0;
    stswrite = 1'b0;
    check("flush_eval_idle", br_ready, 1);
    check("flush_eval_no_redirect", redirect_valid, 0);
    check("flush_eval_no_done", br_done, 0);
    check("flush_eval_status_q", status_q, 3'b011);
    repeat (2) @(negedge clk);

    // Flush in DONE while the redirect is stalled
    redirect_ready = 1'b0;
    send(COND_J, 32'h500, 32'h4, 32'h0, 1'b1, 32'h510, 1'b1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_done_idle", br_ready, 1);
    check("flush_done_no_redirect", redirect_valid, 0);
    check("flush_done_no_done", br_done, 0);
    redirect_ready = 1'b1;

    // br_valid with flush is not accepted
    br_valid = 1'b1;
    br_cond  = COND_J;
    flush    = 1'b1;
    @(negedge clk);
    br_valid = 1'b0;
    flush    = 1'b0;
    check("flush_blocks_accept", dbg_state, ST_IDLE);
    repeat (3) @(negedge clk);

    // Reset mid-DONE with a pending redirect
    redirect_ready = 1'b0;
    send(COND_J, 32'h700, 32'h1, 32'h0, 1'b1, 32'h704, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_redirect", redirect_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_redirect_valid", redirect_valid, 0);
    check("mid_rst_take", take, 0);
    check("mid_rst_target", target, 0);
    check("mid_rst_br_done", br_done, 0);
    check("mid_rst_status_q", status_q, 0);
    check("mid_rst_br_ready", br_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    redirect_ready = 1'b1;
    @(negedge clk);
    check("post_rst_br_ready", br_ready, 1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
